// File: rtl/exu_lsu_if.sv
// ----------------------------------------------------------------------------
// exu_lsu_if
// Load/store bus between the execute-stage LSU and the memory side.
// There is a single request channel and a single response channel, each with
// a valid/ready handshake.
//
//   master (LSU)    : drives ldst_req_*, ldst_rsp_rdy
//   slave  (memory) : drives ldst_req_rdy, ldst_rsp_vld/rdata/err
// ----------------------------------------------------------------------------
interface exu_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic                ldst_req_vld;
    logic                ldst_req_rdy;
    logic [ADDR_W-1:0]   ldst_req_addr;
    logic                ldst_req_wr;
    logic [XLEN-1:0]     ldst_req_wdata;
    logic [XLEN/8-1:0]   ldst_req_strb;
    logic                ldst_rsp_vld;
    logic                ldst_rsp_rdy;
    logic [XLEN-1:0]     ldst_rsp_rdata;
    logic                ldst_rsp_err;

    modport master (
        output ldst_req_vld, ldst_req_addr, ldst_req_wr, ldst_req_wdata,
               ldst_req_strb, ldst_rsp_rdy,
        input  ldst_req_rdy, ldst_rsp_vld, ldst_rsp_rdata, ldst_rsp_err
    );

    modport slave (
        input  ldst_req_vld, ldst_req_addr, ldst_req_wr, ldst_req_wdata,
               ldst_req_strb, ldst_rsp_rdy,
        output ldst_req_rdy, ldst_rsp_vld, ldst_rsp_rdata, ldst_rsp_err
    );
endinterface

// File: rtl/exu_lsu.sv
// ----------------------------------------------------------------------------
// exu_lsu
// Load/store execution unit. It accepts one decoded load/store at a time and
// forms EA = base + sext(imm). It then checks funct3 legality and alignment.
// A legal access issues a single outstanding request on the ldst bus. The
// result goes out on the writeback handshake: extended load data, or an
// exception with its cause and the faulting address.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_*                 operation in (valid/ready), load/store decode fields
//   ldst                  memory bus, master side
//   wb_*                  writeback out (valid/ready), rd write enable + data
//   exc_vld/cause/tval    exception qualifier for the writeback beat
//   busy                  an operation is in flight
// ----------------------------------------------------------------------------
module exu_lsu #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int TMO_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic              req_ld,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_base,
    input  logic [11:0]       req_imm,
    input  logic [XLEN-1:0]   req_sdata,
    input  logic [4:0]        req_rd,
    exu_lsu_if.master         ldst,
    output logic              wb_vld,
    input  logic              wb_rdy,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              exc_vld,
    output logic [3:0]        exc_cause,
    output logic [XLEN-1:0]   exc_tval,
    output logic              busy
);
    localparam int NB     = XLEN / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int CNT_W  = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
    localparam int TMO_LAST = (TMO_CYCLES > 0) ? TMO_CYCLES - 1 : 0;

    localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
    localparam logic [3:0] CAUSE_LD_MISAL = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISAL = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

    typedef enum logic [1:0] {IDLE, REQ, RSP, WB} state_t;

    state_t             state;
    logic [XLEN-1:0]    ea_q;
    logic [OFF_W-1:0]   off_q;
    logic [2:0]         f3_q;
    logic               ld_q;
    logic [4:0]         rd_q;
    logic [CNT_W-1:0]   tmo_cnt;

    // ---------------- accept-time decode ----------------
    logic [XLEN-1:0]    ea_c;
    logic [OFF_W-1:0]   off_c;
    logic               legal_c;
    logic               misal_c;
    logic [7:0]         mask_c;
    logic [NB-1:0]      strb_c;
    logic [XLEN-1:0]    sdata_sh;
    logic [XLEN-1:0]    wdata_c;

    assign ea_c  = req_base + XLEN'($signed(req_imm));
    assign off_c = ea_c[OFF_W-1:0];

    // NOTE: every signal assigned in always_comb gets a default on entry, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        legal_c = 1'b0;
        if (req_ld) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_c = 1'b1;
                3'b011, 3'b110:                         legal_c = (XLEN == 64);
                default:                                legal_c = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: legal_c = 1'b1;
                3'b011:                 legal_c = (XLEN == 64);
                default:                legal_c = 1'b0;
            endcase
        end

        // funct3[1:0] is log2 of the access size in bytes.
        misal_c = 1'b0;
        mask_c  = 8'h00;
        case (req_funct3[1:0])
            2'd0: begin misal_c = 1'b0;          mask_c = 8'h01; end
            2'd1: begin misal_c = ea_c[0];       mask_c = 8'h03; end
            2'd2: begin misal_c = |ea_c[1:0];    mask_c = 8'h0F; end
            default: begin misal_c = |ea_c[2:0]; mask_c = 8'hFF; end
        endcase

        strb_c   = NB'(16'(mask_c) << off_c);
        sdata_sh = req_sdata << {off_c, 3'b000};
        // Lanes outside the byte enables are forced to zero.
        wdata_c  = '0;
        for (int i = 0; i < NB; i++)
            wdata_c[8*i +: 8] = strb_c[i] ? sdata_sh[8*i +: 8] : 8'h00;
    end

    // ---------------- response data extraction ----------------
    logic [XLEN-1:0] rsp_sh;
    logic [XLEN-1:0] ld_ext;

    always_comb begin
        rsp_sh = ldst.ldst_rsp_rdata >> {off_q, 3'b000};
        ld_ext = '0;
        case (f3_q)
            3'b000:  ld_ext = XLEN'($signed(rsp_sh[7:0]));
            3'b001:  ld_ext = XLEN'($signed(rsp_sh[15:0]));
            3'b010:  ld_ext = XLEN'($signed(rsp_sh[31:0]));
            3'b011:  ld_ext = rsp_sh;
            3'b100:  ld_ext = XLEN'(rsp_sh[7:0]);
            3'b101:  ld_ext = XLEN'(rsp_sh[15:0]);
            3'b110:  ld_ext = XLEN'(rsp_sh[31:0]);
            default: ld_ext = '0;
        endcase
    end

    // The unit is always ready for a response. Responses seen outside RSP
    // belong to an abandoned or timed-out request and are simply dropped.
    assign ldst.ldst_rsp_rdy = 1'b1;

    logic tmo_hit;
    assign tmo_hit = (TMO_CYCLES != 0) && (tmo_cnt == CNT_W'(TMO_LAST));

    // ---------------- control FSM, all outputs registered ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            req_rdy             <= 1'b1;
            busy                <= 1'b0;
            ldst.ldst_req_vld   <= 1'b0;
            ldst.ldst_req_addr  <= '0;
            ldst.ldst_req_wr    <= 1'b0;
            ldst.ldst_req_wdata <= '0;
            ldst.ldst_req_strb  <= '0;
            wb_vld              <= 1'b0;
            wb_we               <= 1'b0;
            wb_rd               <= '0;
            wb_data             <= '0;
            exc_vld             <= 1'b0;
            exc_cause           <= '0;
            exc_tval            <= '0;
            ea_q                <= '0;
            off_q               <= '0;
            f3_q                <= '0;
            ld_q                <= 1'b0;
            rd_q                <= '0;
            tmo_cnt             <= '0;
        end else begin
            case (state)
                IDLE: if (req_vld) begin
                    ea_q    <= ea_c;
                    off_q   <= off_c;
                    f3_q    <= req_funct3;
                    ld_q    <= req_ld;
                    rd_q    <= req_rd;
                    req_rdy <= 1'b0;
                    busy    <= 1'b1;
                    wb_rd   <= req_rd;
                    if (!legal_c) begin
                        state     <= WB;
                        wb_vld    <= 1'b1;
                        exc_vld   <= 1'b1;
                        exc_cause <= CAUSE_ILLEGAL;
                        exc_tval  <= '0;
                    end else if (misal_c) begin
                        state     <= WB;
                        wb_vld    <= 1'b1;
                        exc_vld   <= 1'b1;
                        exc_cause <= req_ld ? CAUSE_LD_MISAL : CAUSE_ST_MISAL;
                        exc_tval  <= ea_c;
                    end else begin
                        state               <= REQ;
                        ldst.ldst_req_vld   <= 1'b1;
                        ldst.ldst_req_addr  <= ea_c[ADDR_W-1:0];
                        ldst.ldst_req_wr    <= ~req_ld;
                        ldst.ldst_req_wdata <= wdata_c;
                        ldst.ldst_req_strb  <= strb_c;
                    end
                end
                REQ: if (ldst.ldst_req_rdy) begin
                    state             <= RSP;
                    ldst.ldst_req_vld <= 1'b0;
                    tmo_cnt           <= '0;
                end
                RSP: begin
                    if (ldst.ldst_rsp_vld) begin
                        state  <= WB;
                        wb_vld <= 1'b1;
                        if (ldst.ldst_rsp_err) begin
                            exc_vld   <= 1'b1;
                            exc_cause <= ld_q ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
                            exc_tval  <= ea_q;
                        end else begin
                            wb_data <= ld_q ? ld_ext : '0;
                            wb_we   <= ld_q && (rd_q != 5'd0);
                        end
                    end else if (tmo_hit) begin
                        state     <= WB;
                        wb_vld    <= 1'b1;
                        exc_vld   <= 1'b1;
                        exc_cause <= ld_q ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
                        exc_tval  <= ea_q;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WB: if (wb_rdy) begin
                    state     <= IDLE;
                    req_rdy   <= 1'b1;
                    busy      <= 1'b0;
                    wb_vld    <= 1'b0;
                    wb_we     <= 1'b0;
                    wb_rd     <= '0;
                    wb_data   <= '0;
                    exc_vld   <= 1'b0;
                    exc_cause <= '0;
                    exc_tval  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exu_lsu.sv
// ----------------------------------------------------------------------------
// tb_exu_lsu
// Directed bench for exu_lsu at XLEN=32, ADDR_W=32, TMO_CYCLES=8.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_exu_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld, req_rdy, req_ld;
    logic [2:0]  req_funct3;
    logic [31:0] req_base, req_sdata;
    logic [11:0] req_imm;
    logic [4:0]  req_rd;
    logic        wb_vld, wb_rdy, wb_we, exc_vld, busy;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, exc_tval;
    logic [3:0]  exc_cause;

    int checks   = 0;
    int failures = 0;

    exu_lsu_if #(.XLEN(32), .ADDR_W(32)) ldst ();

    exu_lsu #(.XLEN(32), .ADDR_W(32), .TMO_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_ld     (req_ld),
        .req_funct3 (req_funct3),
        .req_base   (req_base),
        .req_imm    (req_imm),
        .req_sdata  (req_sdata),
        .req_rd     (req_rd),
        .ldst       (ldst),
        .wb_vld     (wb_vld),
        .wb_rdy     (wb_rdy),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .exc_vld    (exc_vld),
        .exc_cause  (exc_cause),
        .exc_tval   (exc_tval),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Presents one operation for a single accepting edge; returns on the
    // falling edge after acceptance (cycle 1 of the operation).
    task automatic start_op(input logic ld, input logic [2:0] f3,
                            input logic [31:0] base, input logic [11:0] imm,
                            input logic [31:0] sdata, input logic [4:0] rd);
        for (int i = 0; i < 20 && !req_rdy; i++) @(negedge clk);
        req_vld = 1'b1; req_ld = ld; req_funct3 = f3; req_base = base;
        req_imm = imm; req_sdata = sdata; req_rd = rd;
        @(negedge clk);
        req_vld = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_vld = 1'b0; req_ld = 1'b0; req_funct3 = '0; req_base = '0;
        req_imm = '0; req_sdata = '0; req_rd = '0; wb_rdy = 1'b1;
        ldst.ldst_req_rdy = 1'b1; ldst.ldst_rsp_vld = 1'b0;
        ldst.ldst_rsp_rdata = '0; ldst.ldst_rsp_err = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_rdy !== 1'b1) begin failures++; $display("FAIL reset_req_rdy: got %b want 1", req_rdy); end
        checks++; if (ldst.ldst_rsp_rdy !== 1'b1) begin failures++; $display("FAIL reset_rsp_rdy: got %b want 1", ldst.ldst_rsp_rdy); end
        checks++; if ({ldst.ldst_req_vld, wb_vld, exc_vld, busy, wb_we} !== 5'b0) begin
            failures++; $display("FAIL reset_outputs: got %b want 00000", {ldst.ldst_req_vld, wb_vld, exc_vld, busy, wb_we}); end
        checks++; if ({ldst.ldst_req_strb, ldst.ldst_req_addr, wb_data, exc_tval} !== '0) begin
            failures++; $display("FAIL reset_fields: strb=%h addr=%h data=%h tval=%h want 0", ldst.ldst_req_strb, ldst.ldst_req_addr, wb_data, exc_tval); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw;
        ldst.ldst_req_rdy = 1'b1; wb_rdy = 1'b1;
        start_op(1'b1, 3'b010, 32'h1000, 12'h004, 32'h0, 5'd5);
        checks++; if ({ldst.ldst_req_vld, ldst.ldst_req_wr, ldst.ldst_req_addr, ldst.ldst_req_strb} !== {1'b1, 1'b0, 32'h1004, 4'hF}) begin
            failures++; $display("FAIL lw_req: vld=%b wr=%b addr=%h strb=%h want 1 0 1004 f", ldst.ldst_req_vld, ldst.ldst_req_wr, ldst.ldst_req_addr, ldst.ldst_req_strb); end
        @(negedge clk);
        checks++; if ({ldst.ldst_req_vld, wb_vld, busy} !== 3'b001) begin
            failures++; $display("FAIL lw_cycle2: req_vld/wb_vld/busy got %b want 001", {ldst.ldst_req_vld, wb_vld, busy}); end
        ldst.ldst_rsp_vld = 1'b1; ldst.ldst_rsp_rdata = 32'h8000_00F0; ldst.ldst_rsp_err = 1'b0;
        @(negedge clk);
        ldst.ldst_rsp_vld = 1'b0;
        checks++; if ({wb_vld, wb_we, exc_vld, req_rdy, wb_rd, wb_data} !== {1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h8000_00F0}) begin
            failures++; $display("FAIL lw_wb: vld=%b we=%b exc=%b req_rdy=%b rd=%0d data=%h want 1 1 0 0 5 800000f0", wb_vld, wb_we, exc_vld, req_rdy, wb_rd, wb_data); end
        @(negedge clk);
        checks++; if ({wb_vld, req_rdy, busy} !== 3'b010) begin
            failures++; $display("FAIL lw_done: wb_vld/req_rdy/busy got %b want 010", {wb_vld, req_rdy, busy}); end
    endtask

    task automatic test_lb_lbu;
        logic [2:0]  f3   [2] = '{3'b000, 3'b100};
        logic [31:0] want [2] = '{32'hFFFF_FF80, 32'h0000_0080};
        for (int i = 0; i < 2; i++) begin
            start_op(1'b1, f3[i], 32'h2000, 12'h003, 32'h0, 5'd7);
            checks++; if ({ldst.ldst_req_addr, ldst.ldst_req_strb} !== {32'h2003, 4'h8}) begin
                failures++; $display("FAIL lb_req[%0d]: addr=%h strb=%h want 2003 8", i, ldst.ldst_req_addr, ldst.ldst_req_strb); end
            @(negedge clk);
            ldst.ldst_rsp_vld = 1'b1; ldst.ldst_rsp_rdata = 32'h8000_0000;
            @(negedge clk);
            ldst.ldst_rsp_vld = 1'b0;
            checks++; if ({wb_vld, wb_we, wb_data} !== {1'b1, 1'b1, want[i]}) begin
                failures++; $display("FAIL lb_data[%0d]: vld=%b we=%b data=%h want 1 1 %h", i, wb_vld, wb_we, wb_data, want[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_sh;
        start_op(1'b0, 3'b001, 32'h1000, 12'h002, 32'h1234_ABCD, 5'd0);
        checks++; if ({ldst.ldst_req_wr, ldst.ldst_req_addr, ldst.ldst_req_strb, ldst.ldst_req_wdata} !== {1'b1, 32'h1002, 4'hC, 32'hABCD_0000}) begin
            failures++; $display("FAIL sh_req: wr=%b addr=%h strb=%h wdata=%h want 1 1002 c abcd0000", ldst.ldst_req_wr, ldst.ldst_req_addr, ldst.ldst_req_strb, ldst.ldst_req_wdata); end
        @(negedge clk);
        ldst.ldst_rsp_vld = 1'b1; ldst.ldst_rsp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        ldst.ldst_rsp_vld = 1'b0;
        checks++; if ({wb_vld, wb_we, exc_vld, wb_data} !== {3'b100, 32'h0}) begin
            failures++; $display("FAIL sh_wb: vld=%b we=%b exc=%b data=%h want 1 0 0 0", wb_vld, wb_we, exc_vld, wb_data); end
        @(negedge clk);
    endtask

    task automatic test_exceptions;
        start_op(1'b1, 3'b010, 32'h1000, 12'h002, 32'h0, 5'd3);
        checks++; if ({ldst.ldst_req_vld, wb_vld, exc_vld, wb_we, exc_cause, exc_tval} !== {4'b0110, 4'd4, 32'h1002}) begin
            failures++; $display("FAIL lw_misal: req_vld=%b wb_vld=%b exc=%b we=%b cause=%0d tval=%h want 0 1 1 0 4 1002", ldst.ldst_req_vld, wb_vld, exc_vld, wb_we, exc_cause, exc_tval); end
        @(negedge clk);
        checks++; if (ldst.ldst_req_vld !== 1'b0) begin failures++; $display("FAIL lw_misal_noreq: got %b want 0", ldst.ldst_req_vld); end
        start_op(1'b0, 3'b011, 32'h1000, 12'h000, 32'h0, 5'd0);
        checks++; if ({ldst.ldst_req_vld, wb_vld, exc_vld, exc_cause, exc_tval} !== {3'b011, 4'd2, 32'h0}) begin
            failures++; $display("FAIL sd_illegal: req_vld=%b wb_vld=%b exc=%b cause=%0d tval=%h want 0 1 1 2 0", ldst.ldst_req_vld, wb_vld, exc_vld, exc_cause, exc_tval); end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        wb_rdy = 1'b0;
        start_op(1'b1, 3'b010, 32'h3000, 12'h000, 32'h0, 5'd7);
        @(negedge clk);          // handshake edge has passed
        repeat (7) @(negedge clk);
        checks++; if (wb_vld !== 1'b0) begin failures++; $display("FAIL tmo_early: wb_vld=%b want 0 at 7 cycles", wb_vld); end
        @(negedge clk);
        checks++; if ({wb_vld, exc_vld, wb_we, exc_cause, exc_tval} !== {3'b110, 4'd5, 32'h3000}) begin
            failures++; $display("FAIL tmo_exc: vld=%b exc=%b we=%b cause=%0d tval=%h want 1 1 0 5 3000", wb_vld, exc_vld, wb_we, exc_cause, exc_tval); end
        wb_rdy = 1'b1;
        @(negedge clk);
        ldst.ldst_rsp_vld = 1'b1; ldst.ldst_rsp_rdata = 32'hBAD0_BAD0;
        checks++; if (ldst.ldst_rsp_rdy !== 1'b1) begin failures++; $display("FAIL late_rsp_rdy: got %b want 1", ldst.ldst_rsp_rdy); end
        @(negedge clk);
        ldst.ldst_rsp_vld = 1'b0;
        checks++; if ({wb_vld, busy, req_rdy} !== 3'b001) begin
            failures++; $display("FAIL late_rsp_drop: wb_vld/busy/req_rdy got %b want 001", {wb_vld, busy, req_rdy}); end
        start_op(1'b1, 3'b010, 32'h4000, 12'h008, 32'h0, 5'd9);
        @(negedge clk);
        ldst.ldst_rsp_vld = 1'b1; ldst.ldst_rsp_rdata = 32'h1234_5678;
        @(negedge clk);
        ldst.ldst_rsp_vld = 1'b0;
        checks++; if ({wb_vld, wb_we, exc_vld, wb_rd, wb_data} !== {3'b110, 5'd9, 32'h1234_5678}) begin
            failures++; $display("FAIL lw_after_tmo: vld=%b we=%b exc=%b rd=%0d data=%h want 1 1 0 9 12345678", wb_vld, wb_we, exc_vld, wb_rd, wb_data); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        ldst.ldst_req_rdy = 1'b0; wb_rdy = 1'b0;
        start_op(1'b1, 3'b010, 32'hFFFF_FFFC, 12'h004, 32'h0, 5'd0);
        for (int c = 0; c < 5; c++) begin
            checks++; if ({ldst.ldst_req_vld, ldst.ldst_req_wr, ldst.ldst_req_addr, ldst.ldst_req_strb, req_rdy} !== {2'b10, 32'h0, 4'hF, 1'b0}) begin
                failures++; $display("FAIL bp_req[%0d]: vld=%b wr=%b addr=%h strb=%h req_rdy=%b want 1 0 0 f 0", c, ldst.ldst_req_vld, ldst.ldst_req_wr, ldst.ldst_req_addr, ldst.ldst_req_strb, req_rdy); end
            if (c < 4) @(negedge clk);
        end
        ldst.ldst_req_rdy = 1'b1;
        @(negedge clk);
        ldst.ldst_rsp_vld = 1'b1; ldst.ldst_rsp_rdata = 32'hA5A5_1234;
        @(negedge clk);
        ldst.ldst_rsp_vld = 1'b0;
        for (int c = 0; c < 3; c++) begin
            // rd = 0: data is returned but the register write is suppressed.
            checks++; if ({wb_vld, wb_we, exc_vld, req_rdy, wb_data} !== {4'b1000, 32'hA5A5_1234}) begin
                failures++; $display("FAIL bp_wb[%0d]: vld=%b we=%b exc=%b req_rdy=%b data=%h want 1 0 0 0 a5a51234", c, wb_vld, wb_we, exc_vld, req_rdy, wb_data); end
            if (c < 2) @(negedge clk);
        end
        wb_rdy = 1'b1;
        @(negedge clk);
        checks++; if ({wb_vld, req_rdy} !== 2'b01) begin
            failures++; $display("FAIL bp_release: wb_vld/req_rdy got %b want 01", {wb_vld, req_rdy}); end
    endtask

    task automatic test_reset_mid;
        start_op(1'b1, 3'b000, 32'h5000, 12'h000, 32'h0, 5'd1);
        @(negedge clk);          // now waiting in RSP
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, req_rdy, wb_vld, ldst.ldst_req_vld} !== 4'b0100) begin
            failures++; $display("FAIL mid_reset: busy/req_rdy/wb_vld/req_vld got %b want 0100", {busy, req_rdy, wb_vld, ldst.ldst_req_vld}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ldst.ldst_rsp_vld = 1'b1; ldst.ldst_rsp_rdata = 32'h0000_00FF;
        @(negedge clk);
        ldst.ldst_rsp_vld = 1'b0;
        @(negedge clk);
        checks++; if ({wb_vld, busy, req_rdy} !== 3'b001) begin
            failures++; $display("FAIL mid_reset_drop: wb_vld/busy/req_rdy got %b want 001", {wb_vld, busy, req_rdy}); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_exceptions();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exu_lsu.md
Name: exu_lsu

Overview:
Parametrised load/store execution unit for the RV core execute stage. It accepts one decoded load/store operation at a time and computes the effective address. It checks alignment and funct3 legality, then drives a single-outstanding request/response transaction on the ldst master port. It returns sign- or zero-extended load data, or an exception, through a writeback handshake. It generalises the execute stage's currently idle ldst port to XLEN 32/64, with configurable response timeout and precise exception reporting.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
ADDR_W, 32, ldst address width (<= XLEN); low ADDR_W bits of effective address are driven.
TMO_CYCLES, 256, response timeout in cycles after request handshake; 0 disables the timeout.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
req_vld  in  1  operation valid
req_rdy  out  1  unit can accept an operation
req_ld  in  1  1 = load, 0 = store
req_funct3  in  3  RV funct3 width/sign code
req_base  in  XLEN  rs1 value
req_imm  in  12  I/S immediate, sign-extended internally
req_sdata  in  XLEN  rs2 store data
req_rd  in  5  load destination register
ldst_req_vld  out  1  memory request valid
ldst_req_rdy  in  1  memory accepts request
ldst_req_addr  out  ADDR_W  byte address
ldst_req_wr  out  1  1 = write
ldst_req_wdata  out  XLEN  lane-aligned write data
ldst_req_strb  out  XLEN/8  byte enables
ldst_rsp_vld  in  1  response valid
ldst_rsp_rdy  out  1  unit accepts response
ldst_rsp_rdata  in  XLEN  full-width read data
ldst_rsp_err  in  1  bus error
wb_vld  out  1  result/exception valid
wb_rdy  in  1  consumer accepts result
wb_we  out  1  register write (load, no exception, rd != 0)
wb_rd  out  5  destination register
wb_data  out  XLEN  extended load data; 0 for stores
exc_vld  out  1  qualifies wb_vld as exception
exc_cause  out  4  2 illegal, 4 ld misaligned, 5 ld fault, 6 st misaligned, 7 st fault
exc_tval  out  XLEN  faulting effective address (0 for cause 2)
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0 except req_rdy=1 and ldst_rsp_rdy=1; timeout counter 0.
- States are IDLE, REQ, RSP and WB. req_rdy=1 only in IDLE; accept on req_vld&req_rdy.
- Effective address EA = req_base + sext(req_imm), modulo 2^XLEN (wrap-around is legal, no fault). Captured at accept.
- Legal funct3, XLEN=32: 000, 001, 010, 100, 101 for loads; 000, 001, 010 for stores. XLEN=64 adds 011 and 110 for loads, and 011 for stores. Other values give cause 2.
- Misaligned means EA not a multiple of the access size (1/2/4/8 bytes); cause 4 or 6.
- IDLE->WB on an illegal or misaligned operation; no ldst request is issued. Otherwise IDLE->REQ.
- REQ: ldst_req_vld=1 on the cycle after accept. Fields stay stable until ldst_req_rdy. On handshake go to RSP and clear the timeout counter.
- Lane offset off = EA mod (XLEN/8).
- ldst_req_strb = ((1<<size)-1)<<off.
- ldst_req_wdata = req_sdata<<(8*off); unused lanes are don't-care but driven 0.
- ldst_req_addr = EA[ADDR_W-1:0].
- RSP: ldst_rsp_rdy=1. On rsp_vld, load data = rdata>>(8*off), truncated to size, then sign-extended (000/001/010/011) or zero-extended (100/101/110). rsp_err gives cause 5 or 7, tval=EA. Go to WB.
- Timeout: counter increments each RSP cycle without rsp_vld. On reaching TMO_CYCLES, give cause 5/7 and go to WB. rsp_vld on the terminal cycle wins over the timeout.
- Late responses: ldst_rsp_rdy=1 in IDLE; responses arriving in IDLE/REQ/WB are accepted and discarded.
- WB: wb_vld=1 and outputs held stable until wb_rdy; then go to IDLE. req_rdy rises on the cycle after the wb handshake (no bypass).
- wb_we=1 only for an error-free load with rd != 0. exc_vld=1 and wb_we=0 on any exception.
- Best-case load latency: accept at cycle 0, ldst_req_vld at 1, rsp at 2, wb_vld at 3.
- Reset mid-operation: return immediately to the reset state; the outstanding request is abandoned, and its response is later discarded in IDLE.

Test Plan:
- LW, XLEN=32, base=0x1000, imm=0x004, rdata=0x8000_00F0, rd=5 -> addr 0x1004, strb 0xF, wb_data 0x8000_00F0, wb_we=1, wb_vld at cycle 3.
- LB vs LBU, EA=0x2003, rdata=0x80_00_00_00 -> strb 0x8; LB wb_data 0xFFFF_FF80, LBU 0x0000_0080.
- SH, base=0x1000, imm=0x002, sdata=0x1234_ABCD -> addr 0x1002, strb 0xC, wdata 0xABCD_0000, wb_we=0.
- LW EA=0x1002 -> no ldst_req_vld ever, exc_cause 4, tval 0x1002. Store funct3=011 at XLEN=32 -> cause 2.
- TMO_CYCLES=8, no response -> exc_cause 5 exactly 8 cycles after request handshake. A later rsp_vld in IDLE is accepted and dropped, and the next LW completes normally.
- Backpressure: hold ldst_req_rdy=0 for 5 cycles and wb_rdy=0 for 3 cycles -> request and wb fields stay stable, req_rdy stays 0, and the wrap case base=0xFFFF_FFFC, imm=0x004 gives addr 0x0.
